// File: rtl/cnn_layer_accel_pfb_loader_if.sv
// cnn_layer_accel_pfb_loader_if: memory read request/response port of the PFB row loader
interface cnn_layer_accel_pfb_loader_if #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_ADDR_WIDTH  = 32
);
  logic                     mem_rd_req_valid;
  logic [C_ADDR_WIDTH-1:0]  mem_rd_req_addr;
  logic                     mem_rd_req_ready;
  logic                     mem_rd_data_valid;
  logic [C_PIXEL_WIDTH-1:0] mem_rd_data;
  modport master (
    output mem_rd_req_valid, mem_rd_req_addr,
    input  mem_rd_req_ready, mem_rd_data_valid, mem_rd_data
  );
  modport slave (
    input  mem_rd_req_valid, mem_rd_req_addr,
    output mem_rd_req_ready, mem_rd_data_valid, mem_rd_data
  );
endinterface

// File: rtl/cnn_layer_accel_pfb_loader.sv
// cnn_layer_accel_pfb_loader: credit-limited row loader feeding a pixel fetch FIFO
module cnn_layer_accel_pfb_loader #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_BRAM_DEPTH  = 1024,
  parameter int C_PFB_DEPTH   = 1024,
  parameter int C_ADDR_WIDTH  = 32
) (
  input  logic                             clk_500MHz,
  input  logic                             accel_rst_n,
  input  logic                             start,
  input  logic [C_ADDR_WIDTH-1:0]          base_addr,
  input  logic [$clog2(C_BRAM_DEPTH)-2:0]  num_input_cols,
  input  logic                             row_request,
  output logic                             row_load_busy,
  output logic                             row_load_done,
  cnn_layer_accel_pfb_loader_if.master     mem,
  input  logic                             pfb_rden,
  output logic [C_PIXEL_WIDTH-1:0]         pfb_dataout,
  output logic                             pfb_dataout_valid,
  output logic                             pfb_empty,
  output logic [17:0]                      pfb_count,
  output logic                             pfb_overflow
);
  localparam int CW = $clog2(C_BRAM_DEPTH) - 1;
  localparam int PW = $clog2(C_PFB_DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;
  state_t state, state_nxt;
  logic [C_ADDR_WIDTH-1:0]  rd_ptr;
  logic [CW-1:0]            cols, issue_cnt, recv_cnt;
  logic [17:0]              outstanding, count_nxt;
  logic [PW:0]              wptr, rptr;
  logic [C_PIXEL_WIDTH-1:0] fifo [C_PFB_DEPTH];
  logic [18:0]              credit;
  logic accept, zero_row, row_end, hs, rsp, full, push, pop;
  assign full      = (wptr ^ rptr) == {1'b1, {PW{1'b0}}};
  assign credit    = {1'b0, pfb_count} + {1'b0, outstanding};
  assign hs        = mem.mem_rd_req_valid && mem.mem_rd_req_ready;
  assign rsp       = mem.mem_rd_data_valid && state != ST_IDLE;
  assign push      = rsp && !full;
  assign pop       = pfb_rden && !pfb_empty;
  assign count_nxt = pfb_count + 18'(push) - 18'(pop);
  assign mem.mem_rd_req_addr = rd_ptr;
  always_ff @(posedge clk_500MHz)
    if (!accel_rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt = issue_cnt == cols ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_nxt = row_end ? ST_IDLE : ST_DRAIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end
  // Credits count FIFO entries plus reads in flight, so a granted read always has a slot.
  always_comb begin
    accept   = state == ST_IDLE && row_request && num_input_cols != '0;
    zero_row = state == ST_IDLE && row_request && num_input_cols == '0;
    row_end  = state == ST_DRAIN && recv_cnt == cols;
    mem.mem_rd_req_valid = state == ST_ISSUE && issue_cnt < cols && credit < 19'(C_PFB_DEPTH);
  end
  always_ff @(posedge clk_500MHz) begin
    if (!accel_rst_n) begin
      rd_ptr            <= '0;
      cols              <= '0;
      issue_cnt         <= '0;
      recv_cnt          <= '0;
      outstanding       <= '0;
      wptr              <= '0;
      rptr              <= '0;
      row_load_busy     <= 1'b0;
      row_load_done     <= 1'b0;
      pfb_dataout       <= '0;
      pfb_dataout_valid <= 1'b0;
      pfb_count         <= '0;
      pfb_empty         <= 1'b1;
      pfb_overflow      <= 1'b0;
    end else begin
      if (start && state == ST_IDLE) rd_ptr <= base_addr;
      else if (hs) rd_ptr <= rd_ptr + C_ADDR_WIDTH'(1);
      if (accept) begin
        cols      <= num_input_cols;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        issue_cnt <= issue_cnt + CW'(hs);
        recv_cnt  <= recv_cnt + CW'(rsp);
      end
      outstanding       <= outstanding + 18'(hs) - 18'(rsp);
      row_load_busy     <= accept || (row_load_busy && !row_end);
      row_load_done     <= zero_row || row_end;
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop) begin
        rptr        <= rptr + (PW+1)'(1);
        pfb_dataout <= fifo[rptr[PW-1:0]];
      end
      pfb_dataout_valid <= pop;
      pfb_count         <= count_nxt;
      pfb_empty         <= count_nxt == '0;
      pfb_overflow      <= pfb_overflow || (rsp && full);
    end
  end
  always_ff @(posedge clk_500MHz)
    if (accel_rst_n && push) fifo[wptr[PW-1:0]] <= mem.mem_rd_data;
endmodule

// File: tb/tb_cnn_layer_accel_pfb_loader.sv
// tb_cnn_layer_accel_pfb_loader: directed vectors and corner sequences for the PFB row loader
module tb_cnn_layer_accel_pfb_loader;
  localparam int PXW = 16;
  localparam int BD  = 1024;
  localparam int PD  = 16;
  localparam int AW  = 32;
  typedef struct {
    logic        rden;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [17:0] exp_count;
    logic        exp_empty;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, row_request = 0, pfb_rden = 0, ready = 1, toggle = 0;
  logic [AW-1:0] base_addr = '0;
  logic [8:0] cols = '0;
  logic busy, done, dvalid, empty, overflow;
  logic [PXW-1:0] dout;
  logic [17:0] count;
  int errors = 0, checks = 0, done_cnt = 0, stab_err = 0;
  logic p1v = 0, rv = 0, stall = 0;
  logic [15:0] p1d = '0, rd = '0;
  logic [AW-1:0] paddr = '0;
  logic [AW-1:0] issued[$];
  vec_t tbl[10];

  always #1 clk = ~clk;

  cnn_layer_accel_pfb_loader_if #(.C_PIXEL_WIDTH(PXW), .C_ADDR_WIDTH(AW)) mem_if();
  assign mem_if.mem_rd_req_ready  = ready;
  assign mem_if.mem_rd_data_valid = rv;
  assign mem_if.mem_rd_data       = rd;

  cnn_layer_accel_pfb_loader #(
    .C_PIXEL_WIDTH(PXW), .C_BRAM_DEPTH(BD), .C_PFB_DEPTH(PD), .C_ADDR_WIDTH(AW)
  ) dut (
    .clk_500MHz(clk), .accel_rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_input_cols(cols), .row_request(row_request), .row_load_busy(busy),
    .row_load_done(done), .mem(mem_if), .pfb_rden(pfb_rden), .pfb_dataout(dout),
    .pfb_dataout_valid(dvalid), .pfb_empty(empty), .pfb_count(count), .pfb_overflow(overflow)
  );

  // memory: answers each accepted read two cycles later with the low address bits as data
  always @(posedge clk) begin
    p1v <= mem_if.mem_rd_req_valid && ready;
    p1d <= mem_if.mem_rd_req_addr[15:0];
    rv  <= p1v;
    rd  <= p1d;
    if (mem_if.mem_rd_req_valid && ready) issued.push_back(mem_if.mem_rd_req_addr);
    if (stall && (!mem_if.mem_rd_req_valid || mem_if.mem_rd_req_addr != paddr)) stab_err <= stab_err + 1;
    stall <= mem_if.mem_rd_req_valid && !ready;
    paddr <= mem_if.mem_rd_req_addr;
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) if (toggle) ready = ~ready;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_row(input logic [AW-1:0] base, input logic [8:0] n);
    start = 1; base_addr = base; cols = n; row_request = 1;
    cyc(1);
    start = 0; row_request = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 200) begin cyc(1); n++; end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic pop(input logic [15:0] exp, input string nm);
    pfb_rden = 1;
    cyc(1);
    pfb_rden = 0;
    chk(nm, 64'({dvalid, dout}), 64'({1'b1, exp}));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"},  64'(busy), 64'd0);
    chk({nm, "_done"},  64'(done), 64'd0);
    chk({nm, "_reqv"},  64'(mem_if.mem_rd_req_valid), 64'd0);
    chk({nm, "_dout"},  64'({dvalid, dout}), 64'd0);
    chk({nm, "_empty"}, 64'(empty), 64'd1);
    chk({nm, "_count"}, 64'(count), 64'd0);
    chk({nm, "_ovf"},   64'(overflow), 64'd0);
  endtask

  task automatic chk_addrs(input string nm, input logic [AW-1:0] base, input int n);
    chk({nm, "_nreq"}, 64'(issued.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_addr%0d", nm, i), 64'((i < issued.size()) ? issued[i] : 32'hdead_beef), 64'(base + AW'(i)));
  endtask

  initial begin
    int n, d0;
    logic seen;
    tbl[0] = '{1'b1, 1'b1, 16'h0100, 18'd7, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h0101, 18'd6, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h0102, 18'd5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h0103, 18'd4, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h0104, 18'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0105, 18'd2, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h0106, 18'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'h0107, 18'd0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 16'h0107, 18'd0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 16'h0107, 18'd0, 1'b1};
    rst_n = 0;
    cyc(3);
    chk_reset("rst");
    rst_n = 1;
    cyc(1);
    // basic row
    issued.delete();
    load_row(32'h100, 9'd8);
    chk("basic_busy_on", 64'(busy), 64'd1);
    wait_done("basic_done");
    chk("basic_busy_off", 64'(busy), 64'd0);
    chk("basic_count", 64'(count), 64'd8);
    chk_addrs("basic", 32'h100, 8);
    cyc(1);
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    // drain table
    for (int i = 0; i < 10; i++) begin
      pfb_rden = tbl[i].rden;
      cyc(1);
      chk($sformatf("drain%0d", i), 64'({dvalid, dout, count, empty}),
          64'({tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_count, tbl[i].exp_empty}));
    end
    pfb_rden = 0;
    // backpressure
    issued.delete();
    toggle = 1;
    load_row(32'h200, 9'd8);
    wait_done("bp_done");
    toggle = 0;
    ready = 1;
    chk_addrs("bp", 32'h200, 8);
    chk("bp_stable", 64'(stab_err), 64'd0);
    cyc(1);
    for (int i = 0; i < 8; i++) pop(16'(32'h200 + i), $sformatf("bp_pop%0d", i));
    chk("bp_empty", 64'({count, empty}), 64'({18'd0, 1'b1}));
    // credit limit
    issued.delete();
    load_row(32'h300, 9'd12);
    wait_done("pre_done");
    chk("pre_count", 64'(count), 64'd12);
    issued.delete();
    load_row(32'h400, 9'd8);
    cyc(20);
    chk("credit_nreq", 64'(issued.size()), 64'd4);
    chk("credit_reqv_low", 64'(mem_if.mem_rd_req_valid), 64'd0);
    chk("credit_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) pop(16'(32'h300 + i), $sformatf("credit_pop%0d", i));
    wait_done("credit_done");
    chk_addrs("credit", 32'h400, 8);
    chk("credit_count", 64'(count), 64'd16);
    chk("credit_ovf", 64'(overflow), 64'd0);
    cyc(1);
    for (int i = 0; i < 8; i++) pop(16'(32'h304 + i), $sformatf("credit_drain_a%0d", i));
    for (int i = 0; i < 8; i++) pop(16'(32'h400 + i), $sformatf("credit_drain_b%0d", i));
    chk("credit_empty", 64'({count, empty}), 64'({18'd0, 1'b1}));
    // push and pop in the same cycle, plus row_request while busy
    load_row(32'h500, 9'd5);
    wait_done("sim_pre_done");
    chk("sim_pre_count", 64'(count), 64'd5);
    issued.delete();
    cyc(1);
    d0 = done_cnt;
    load_row(32'h600, 9'd1);
    row_request = 1;
    cyc(1);
    row_request = 0;
    n = 0;
    while (!rv && n < 20) begin cyc(1); n++; end
    seen = rv;
    chk("sim_rsp_seen", 64'(seen), 64'd1);
    pfb_rden = 1;
    cyc(1);
    pfb_rden = 0;
    chk("sim_count", 64'(count), 64'd5);
    chk("sim_pop", 64'({dvalid, dout}), 64'({1'b1, 16'h0500}));
    wait_done("sim_done");
    cyc(25);
    chk("sim_one_done", 64'(done_cnt - d0), 64'd1);
    chk("sim_nreq", 64'(issued.size()), 64'd1);
    for (int i = 0; i < 4; i++) pop(16'(32'h501 + i), $sformatf("sim_drain%0d", i));
    pop(16'h0600, "sim_drain4");
    // zero-length row
    cols = '0;
    row_request = 1;
    cyc(1);
    row_request = 0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    cyc(1);
    chk("zero_pulse", 64'(done), 64'd0);
    // reset in the middle of a row
    load_row(32'h700, 9'd8);
    n = 0;
    while (count != 18'd3 && n < 100) begin cyc(1); n++; end
    chk("mid_count", 64'(count), 64'd3);
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    chk_reset("mid_rst");
    cyc(10);
    chk("mid_discard", 64'({count, empty}), 64'({18'd0, 1'b1}));
    issued.delete();
    load_row(32'h800, 9'd4);
    wait_done("mid_new_done");
    chk("mid_new_count", 64'(count), 64'd4);
    chk_addrs("mid_new", 32'h800, 4);
    cyc(1);
    for (int i = 0; i < 4; i++) pop(16'(32'h800 + i), $sformatf("mid_pop%0d", i));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_pfb_loader.md
Name: cnn_layer_accel_pfb_loader

Overview:
Pixel fetch buffer (PFB) plus row loader that sits directly upstream of the octo BRAM controller.
- On a row_request pulse it issues num_input_cols sequential pixel reads to the memory read port.
- It collects the returned pixels into an internal FIFO.
- It exposes the FIFO to the controller through pfb_rden, pfb_count, pfb_empty and pfb_dataout_valid.
- Outstanding reads are credit-limited so the FIFO never overflows.

Parameters:
C_PIXEL_WIDTH, 16, pixel data width.
C_BRAM_DEPTH, 1024, sets the width of num_input_cols to clog2(C_BRAM_DEPTH)-1 bits.
C_PFB_DEPTH, 1024, FIFO entries; must be a power of 2 and no greater than 2^17.
C_ADDR_WIDTH, 32, memory address width in pixels.

Ports:
clk_500MHz  in  1  single clock
accel_rst_n  in  1  synchronous, active-low reset
start  in  1  pulse; latches base_addr into the read pointer
base_addr  in  C_ADDR_WIDTH  first pixel address of the layer
num_input_cols  in  clog2(C_BRAM_DEPTH)-1  pixels per row request
row_request  in  1  pulse; load one row
row_load_busy  out  1  high from accept until last response of the row
row_load_done  out  1  1-cycle pulse when the row's last pixel is written
mem_rd_req_valid  out  1  read request valid
mem_rd_req_addr  out  C_ADDR_WIDTH  read address
mem_rd_req_ready  in  1  memory accepts the request
mem_rd_data_valid  in  1  read response valid; in order, cannot be stalled
mem_rd_data  in  C_PIXEL_WIDTH  response pixel
pfb_rden  in  1  pop one pixel
pfb_dataout  out  C_PIXEL_WIDTH  popped pixel
pfb_dataout_valid  out  1  pfb_dataout valid this cycle
pfb_empty  out  1  FIFO holds 0 entries
pfb_count  out  18  FIFO occupancy
pfb_overflow  out  1  sticky error flag

Behaviour:
- Reset (accel_rst_n=0 at a clock edge) clears all outputs to 0 except pfb_empty, which resets to 1. It also clears rd_ptr, the FIFO pointers, the outstanding-read counter, the issue and receive counters, and returns the FSM to ST_IDLE. Reset mid-row abandons the row; responses arriving after reset are discarded until the next accepted row_request.
- start: rd_ptr <= base_addr. It is ignored unless the FSM is in ST_IDLE. In ST_IDLE, start together with row_request: the row uses the new base_addr.
- FSM states:
  - ST_IDLE: on row_request with num_input_cols != 0, go to ST_ISSUE. Clear issue_cnt and recv_cnt; row_load_busy <= 1. If num_input_cols == 0, emit row_load_done the next cycle and stay in ST_IDLE.
  - ST_ISSUE: mem_rd_req_valid = 1 while issue_cnt < num_input_cols and (pfb_count + outstanding) < C_PFB_DEPTH.
    - mem_rd_req_addr = rd_ptr.
    - On valid && ready: rd_ptr++, issue_cnt++, outstanding++.
    - When issue_cnt reaches num_input_cols, go to ST_DRAIN.
    - valid/addr stay stable until ready. A credit drop can only lower valid before a handshake, never mid-handshake.
  - ST_DRAIN: wait until recv_cnt == num_input_cols. Then pulse row_load_done for 1 cycle, set row_load_busy <= 0 in the same cycle, and return to ST_IDLE.
- row_request while not in ST_IDLE is ignored. The consumer gates requests with row_load_busy.
- Responses:
  - Each mem_rd_data_valid writes mem_rd_data to the FIFO, increments recv_cnt, and decrements outstanding.
  - Valid responses are accepted in ST_ISSUE and ST_DRAIN.
  - A write to a full FIFO is dropped and sets pfb_overflow; only reset clears it. This case is unreachable under correct credits.
- Read side:
  - pfb_rden with FIFO non-empty pops one entry; pfb_dataout/pfb_dataout_valid are registered and valid exactly 1 cycle later.
  - pfb_rden while empty is ignored; pfb_dataout_valid=0 the next cycle and pfb_dataout holds its previous value.
- pfb_count and pfb_empty are registered and updated the cycle after a push or pop.
  - Push and pop in the same cycle: count unchanged.
  - Pop on count==1 with no push: count=0 and empty=1 the next cycle.
  - Push when empty with a simultaneous pop: the pop is ignored because the FIFO is empty in that cycle.
- Pointer and counter widths:
  - FIFO pointers are clog2(C_PFB_DEPTH) bits plus 1 wrap bit.
  - rd_ptr wraps modulo 2^C_ADDR_WIDTH.
  - outstanding counter is 18 bits.

Test Plan:
- Basic row: reset; start with base_addr=0x100, num_input_cols=8; row_request; ready=1; responses 2 cycles after each request with data=addr.
  -> addresses 0x100..0x107 in order; row_load_busy high until the last write; row_load_done pulse; pfb_count=8.
- Drain: after the basic row, pfb_rden for 8 consecutive cycles -> pfb_dataout 0x100..0x107, each valid 1 cycle after its rden; pfb_empty=1; count=0. A 9th rden -> no dataout_valid.
- Backpressure: mem_rd_req_ready toggling 1/0 -> addr stays constant while not ready; no duplicate or skipped addresses; exactly 8 handshakes.
- Credit limit: C_PFB_DEPTH=16; preload 12 entries; row of 8; no pops -> only 4 requests issued until pops occur. Pop 4 -> the remaining 4 issue; pfb_overflow stays 0; final count=16.
- Simultaneous events: push and pop in the same cycle at count=5 -> count stays 5. row_request during busy -> ignored; exactly one row_load_done.
- Mid-row reset: assert accel_rst_n=0 after 3 of 8 responses -> all outputs reset; pfb_empty=1; FSM idle. A new row_request loads cleanly from the new start/base_addr.
